regfile_mp_sb: RTL and testbench

- Parametrised multi-port integer register file for the pipelined core. It is the successor to the single-write, dual-read RF.
- Adds the following:
  - N read ports with write-through bypass.
  - M write ports with fixed priority.
  - A per-register busy scoreboard for hazard detection.
  - Flush.
  - A registered debug read port.
- Sits between decode (reads, issue), writeback (writes, retire) and the debug/LED I/O logic.

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_scoreboard.sv | 52 +++++
 rtl/regfile_mp_sb.sv | 114 +++++++++++
 tb/tb_regfile_mp_sb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package rf_pkg;

  localparam int ZERO_REG       = 0;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_REGS_DEF   = 32;

  // LSB offset of port k in a bus that packs ports of width w side by side.
  function automatic int pack_idx(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set when a producer issues, cleared when it retires or on flush.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_WR   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     flush,
  output logic [NUM_REGS-1:0]      busy_o
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Retire clears first so a same-cycle issue to the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j]) begin
          busy_d[wr_addr[pack_idx(j, ADDR_W) +: ADDR_W]] = 1'b0;
        end
      end
      if (iss_en && (iss_addr != ZERO_IDX)) begin
        busy_d[iss_addr] = 1'b1;
      end
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-through read bypass, busy scoreboard,
// registered debug read and a live LED mirror of one register.
module regfile_mp_sb
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int ADDR_W     = $clog2(NUM_REGS),
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int LED_REG    = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         iss_en,
  input  logic [ADDR_W-1:0]            iss_addr,
  input  logic                         flush,
  input  logic [ADDR_W-1:0]            dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_data,
  output logic [DATA_WIDTH-1:0]        led_o
);

  if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_bad_num_rd
    $error("regfile_mp_sb: NUM_RD must be in 1..4");
  end
  if ((NUM_WR < 1) || (NUM_WR > 2)) begin : g_bad_num_wr
    $error("regfile_mp_sb: NUM_WR must be in 1..2");
  end
  if ((NUM_REGS < 2) || ((NUM_REGS & (NUM_REGS - 1)) != 0)) begin : g_bad_num_regs
    $error("regfile_mp_sb: NUM_REGS must be a power of 2 and at least 2");
  end

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LED_IDX  = ADDR_W'(LED_REG);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] dbg_q;
  logic [DATA_WIDTH-1:0] dbg_d;
  logic [NUM_REGS-1:0]   busy;

  // Later ports overwrite earlier ones, giving port NUM_WR-1 priority.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        regs_d[wr_addr[pack_idx(j, ADDR_W) +: ADDR_W]] = wr_data[pack_idx(j, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
    regs_d[ZERO_REG] = '0;
  end

  // Debug sees pre-write contents; regs_q[0] is held at zero so address 0 reads 0.
  always_comb begin
    dbg_d = regs_q[dbg_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      dbg_q <= '0;
    end else begin
      regs_q <= regs_d;
      dbg_q  <= dbg_d;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_WIDTH-1:0] v;
    v = regs_q[a];
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wr_addr[pack_idx(j, ADDR_W) +: ADDR_W] == a) && (a != ZERO_IDX)) begin
        v = wr_data[pack_idx(j, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
    return v;
  endfunction

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[pack_idx(k, DATA_WIDTH) +: DATA_WIDTH] = read_port(rd_addr[pack_idx(k, ADDR_W) +: ADDR_W]);
      rd_busy[k] = busy[rd_addr[pack_idx(k, ADDR_W) +: ADDR_W]];
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .flush    (flush),
    .busy_o   (busy)
  );

  assign dbg_data = dbg_q;
  assign led_o    = regs_q[LED_IDX];

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: stimulus queues timestamped expectations, a negedge monitor checks them.
module tb_regfile_mp_sb;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int RDP = 2;
  localparam int WRP = 2;

  localparam int S_RD0 = 0;
  localparam int S_RD1 = 1;
  localparam int S_BS0 = 2;
  localparam int S_BS1 = 3;
  localparam int S_DBG = 4;
  localparam int S_LED = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [RDP*AW-1:0] rd_addr;
  logic [RDP*DW-1:0] rd_data;
  logic [RDP-1:0]    rd_busy;
  logic [WRP-1:0]    wr_en;
  logic [WRP*AW-1:0] wr_addr;
  logic [WRP*DW-1:0] wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              flush;
  logic [AW-1:0]     dbg_addr;
  logic [DW-1:0]     dbg_data;
  logic [DW-1:0]     led_o;

  regfile_mp_sb #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .NUM_RD     (RDP),
    .NUM_WR     (WRP),
    .LED_REG    (11)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .led_o    (led_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          when;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_RD0:   return rd_data[31:0];
      S_RD1:   return rd_data[63:32];
      S_BS0:   return {31'b0, rd_busy[0]};
      S_BS1:   return {31'b0, rd_busy[1]};
      S_DBG:   return dbg_data;
      default: return led_o;
    endcase
  endfunction

  // Monitor: every negedge, compare all expectations due this cycle.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].when == cyc) begin
        checks <= checks + 1;
        if (actual(q[i].sel) !== q[i].val) begin
          errors <= errors + 1;
          $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", q[i].name, actual(q[i].sel), q[i].val, cyc);
        end
        q.delete(i);
      end else if (q[i].when < cyc) begin
        errors <= errors + 1;
        $display("FAIL %s: expectation for cycle %0d never checked", q[i].name, q[i].when);
        q.delete(i);
      end
    end
  end

  task automatic exp_now(input int sel, input logic [31:0] val, input string name);
    exp_t e;
    e.when = cyc; e.sel = sel; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic exp_next(input int sel, input logic [31:0] val, input string name);
    exp_t e;
    e.when = cyc + 1; e.sel = sel; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic defaults();
    rst = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0; dbg_addr = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    defaults();
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wr(input logic [1:0] en, input logic [AW-1:0] a0, input logic [31:0] d0,
                    input logic [AW-1:0] a1, input logic [31:0] d1);
    wr_en = en; wr_addr = {a1, a0}; wr_data = {d1, d0};
  endtask

  task automatic issue(input logic [AW-1:0] a);
    iss_en = 1'b1; iss_addr = a;
  endtask

  initial begin
    defaults();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    defaults();

    // Reset: x5 written, then reset with competing writes/issues in the same cycle
    wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0); rd(5'd5, 5'd0);
    exp_now(S_RD0, 32'hDEADBEEF, "bypass_x5");
    next_cycle();
    rst = 1'b1; rd(5'd5, 5'd0); dbg_addr = 5'd5;
    exp_now(S_RD0, 32'hDEADBEEF, "stored_x5");
    wr(2'b01, 5'd11, 32'h1111, 5'd0, 32'h0); issue(5'd5);
    next_cycle();
    rd(5'd5, 5'd11); dbg_addr = 5'd5;
    exp_now(S_RD0, 32'h0, "reset_rd_x5");
    exp_now(S_RD1, 32'h0, "reset_rd_x11");
    exp_now(S_BS0, 32'h0, "reset_busy_x5");
    exp_now(S_DBG, 32'h0, "reset_dbg");
    exp_now(S_LED, 32'h0, "reset_led");
    next_cycle();

    // Zero register
    wr(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0); issue(5'd0); rd(5'd0, 5'd0);
    exp_now(S_RD0, 32'h0, "x0_bypass");
    next_cycle();
    rd(5'd0, 5'd0);
    exp_now(S_RD0, 32'h0, "x0_stored");
    exp_now(S_BS0, 32'h0, "x0_busy");
    next_cycle();

    // Write priority and bypass
    wr(2'b11, 5'd7, 32'hAAAA, 5'd7, 32'h5555); rd(5'd7, 5'd7);
    exp_now(S_RD0, 32'h5555, "prio_bypass0");
    exp_now(S_RD1, 32'h5555, "prio_bypass1");
    next_cycle();
    rd(5'd7, 5'd0);
    wr(2'b11, 5'd8, 32'h8888, 5'd10, 32'h1010);
    exp_now(S_RD0, 32'h5555, "prio_stored");
    exp_now(S_RD1, 32'h0, "x0_read_port1");
    next_cycle();
    rd(5'd8, 5'd10);
    exp_now(S_RD0, 32'h8888, "dual_wr_x8");
    exp_now(S_RD1, 32'h1010, "dual_wr_x10");
    next_cycle();

    // Scoreboard
    issue(5'd9); rd(5'd9, 5'd0);
    exp_now(S_BS0, 32'h0, "busy_x9_before");
    next_cycle();
    issue(5'd9); wr(2'b01, 5'd9, 32'h99, 5'd0, 32'h0); rd(5'd9, 5'd0);
    exp_now(S_BS0, 32'h1, "busy_x9_set");
    next_cycle();
    wr(2'b10, 5'd0, 32'h0, 5'd9, 32'h9999); rd(5'd9, 5'd0);
    exp_now(S_BS0, 32'h1, "busy_x9_set_wins");
    exp_now(S_RD0, 32'h9999, "x9_bypass_port1");
    next_cycle();
    rd(5'd9, 5'd0);
    exp_now(S_BS0, 32'h0, "busy_x9_cleared");
    exp_now(S_RD0, 32'h9999, "x9_stored");
    next_cycle();

    // Flush
    issue(5'd3);
    next_cycle();
    issue(5'd4);
    next_cycle();
    issue(5'd31); rd(5'd3, 5'd4);
    exp_now(S_BS0, 32'h1, "busy_x3");
    exp_now(S_BS1, 32'h1, "busy_x4");
    next_cycle();
    flush = 1'b1; issue(5'd6); wr(2'b01, 5'd12, 32'h00C0FFEE, 5'd0, 32'h0); rd(5'd31, 5'd0);
    exp_now(S_BS0, 32'h1, "busy_x31");
    next_cycle();
    rd(5'd3, 5'd4);
    exp_now(S_BS0, 32'h0, "flush_x3");
    exp_now(S_BS1, 32'h0, "flush_x4");
    next_cycle();
    rd(5'd31, 5'd6);
    exp_now(S_BS0, 32'h0, "flush_x31");
    exp_now(S_BS1, 32'h0, "flush_x6_issue");
    next_cycle();
    rd(5'd12, 5'd0);
    exp_now(S_RD0, 32'h00C0FFEE, "flush_keeps_write");
    next_cycle();

    // Debug and LED
    wr(2'b01, 5'd11, 32'hFF, 5'd0, 32'h0); dbg_addr = 5'd11;
    exp_now(S_LED, 32'h0, "led_no_bypass");
    exp_next(S_DBG, 32'h0, "dbg_old_value");
    next_cycle();
    dbg_addr = 5'd11;
    exp_now(S_LED, 32'hFF, "led_ff");
    exp_next(S_DBG, 32'hFF, "dbg_ff");
    next_cycle();
    wr(2'b10, 5'd0, 32'h0, 5'd11, 32'hF0); dbg_addr = 5'd11;
    exp_next(S_DBG, 32'hFF, "dbg_pre_write");
    next_cycle();
    dbg_addr = 5'd0;
    exp_now(S_LED, 32'hF0, "led_f0");
    exp_next(S_DBG, 32'h0, "dbg_x0");
    next_cycle();
    dbg_addr = 5'd11;
    exp_next(S_DBG, 32'hF0, "dbg_f0");
    next_cycle();

    repeat (3) next_cycle();
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d pending, expected 0", q.size());
      errors = errors + q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
